// File: rtl/score_bcd_keeper_if.sv
// ----------------------------------------------------------------------------
// score_bcd_keeper_if : shot handshake and digit/scan outputs of the score keeper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface score_bcd_keeper_if;
    logic       clr;
    logic       shot_valid;
    logic [1:0] shot_pts;
    logic       shot_ready;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       dp1;
    logic       dp0;
    logic       scan_en;
    logic       busy;

    modport master (
        output clr, shot_valid, shot_pts,
        input  shot_ready, d1, d0, dp1, dp0, scan_en, busy
    );

    modport slave (
        input  clr, shot_valid, shot_pts,
        output shot_ready, d1, d0, dp1, dp0, scan_en, busy
    );
endinterface

`default_nettype wire

// File: rtl/score_bcd_keeper.sv
// ----------------------------------------------------------------------------
// score_bcd_keeper : two-digit BCD score with shot handshake, scan strobe and
//                    post-score "new score" hold window
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module score_bcd_keeper #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int SCAN_HZ    = 4000,
    parameter int HOLD_TICKS = 400
) (
    input  wire logic           clk,
    input  wire logic           rst,
    score_bcd_keeper_if.slave   bus
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] c_div_last = CNT_W'(DIV - 1);
    localparam logic [15:0]      c_hold     = 16'(HOLD_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_scan;
    logic [1:0]       r_pending, w_pending_nx;
    logic [15:0]      r_hold, w_hold_nx;
    logic [3:0]       r_d1, w_d1_nx;
    logic [3:0]       r_d0, w_d0_nx;
    logic             r_dp1, w_dp1_nx;
    logic             w_sat;

    // Scan divider runs free of clr so the display scan never stutters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_scan <= 1'b0;
        end else begin
            r_scan <= (r_cnt == c_div_last);
            r_cnt  <= (r_cnt == c_div_last) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= 2'd0;
            r_hold    <= 16'd0;
            r_d1      <= 4'd0;
            r_d0      <= 4'd0;
            r_dp1     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_pending <= w_pending_nx;
            r_hold    <= w_hold_nx;
            r_d1      <= w_d1_nx;
            r_d0      <= w_d0_nx;
            r_dp1     <= w_dp1_nx;
        end
    end

    assign w_sat = (r_d1 == 4'd9) && (r_d0 == 4'd9);

    always_comb begin
        w_state_nx   = r_state;
        w_pending_nx = r_pending;
        w_hold_nx    = r_hold;
        w_d1_nx      = r_d1;
        w_d0_nx      = r_d0;
        w_dp1_nx     = r_dp1;
        if (bus.clr) begin
            w_state_nx   = ST_IDLE;
            w_pending_nx = 2'd0;
            w_hold_nx    = 16'd0;
            w_d1_nx      = 4'd0;
            w_d0_nx      = 4'd0;
            w_dp1_nx     = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.shot_valid && (bus.shot_pts != 2'd0)) begin
                        w_pending_nx = bus.shot_pts;
                        w_state_nx   = ST_ADD;
                    end
                end
                ST_ADD: begin
                    // At 99 the points still drain one per cycle; only the flag moves.
                    if (w_sat) begin
                        w_dp1_nx = 1'b1;
                    end else if (r_d0 == 4'd9) begin
                        w_d0_nx = 4'd0;
                        w_d1_nx = r_d1 + 4'd1;
                    end else begin
                        w_d0_nx = r_d0 + 4'd1;
                    end
                    w_pending_nx = r_pending - 2'd1;
                    if (r_pending == 2'd1) begin
                        if (c_hold == 16'd0) begin
                            w_state_nx = ST_IDLE;
                        end else begin
                            w_state_nx = ST_HOLD;
                            w_hold_nx  = c_hold;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_scan) begin
                        w_hold_nx = r_hold - 16'd1;
                        if (r_hold == 16'd1) begin
                            w_state_nx = ST_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.shot_ready = (r_state == ST_IDLE) && !bus.clr;
    assign bus.d1         = r_d1;
    assign bus.d0         = r_d0;
    assign bus.dp1        = r_dp1;
    assign bus.dp0        = (r_state == ST_HOLD);
    assign bus.scan_en    = r_scan;
    assign bus.busy       = (r_state == ST_ADD) || (r_state == ST_HOLD);

endmodule

`default_nettype wire

// File: tb/tb_score_bcd_keeper.sv
// ----------------------------------------------------------------------------
// tb_score_bcd_keeper : randomized and directed checks against a score model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_score_bcd_keeper;

    localparam int CLK_HZ     = 400;
    localparam int SCAN_HZ    = 100;
    localparam int HOLD_TICKS = 2;
    localparam int DIV        = CLK_HZ / SCAN_HZ;

    logic clk = 1'b0;
    logic rst = 1'b1;

    score_bcd_keeper_if bus ();

    score_bcd_keeper #(
        .CLK_HZ     (CLK_HZ),
        .SCAN_HZ    (SCAN_HZ),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: score as an integer, points still owed, scan ticks left in the window.
    int m_score    = 0;
    int m_owed     = 0;
    int m_hold     = 0;
    int m_sat      = 0;
    int m_cyc      = 0;
    int m_scan     = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int m_idle();
        return (m_owed == 0 && m_hold == 0) ? 1 : 0;
    endfunction

    task automatic model_edge(input int r, input int c, input int v, input int p);
        int scan_before;
        scan_before = m_scan;
        if (r != 0) begin
            m_score = 0; m_owed = 0; m_hold = 0; m_sat = 0; m_cyc = 0;
        end else begin
            m_cyc++;
            if (c != 0) begin
                m_score = 0; m_owed = 0; m_hold = 0; m_sat = 0;
            end else if (m_owed > 0) begin
                if (m_score == 99) m_sat = 1;
                else m_score++;
                m_owed--;
                if (m_owed == 0) m_hold = HOLD_TICKS;
            end else if (m_hold > 0) begin
                if (scan_before != 0) m_hold--;
            end else if (v != 0 && p != 0) begin
                m_owed = p;
            end
        end
        m_scan = (m_cyc > 0 && (m_cyc % DIV) == 0) ? 1 : 0;
    endtask

    task automatic check_outputs(input int c);
        check_eq("d1",         int'(bus.d1),         m_score / 10);
        check_eq("d0",         int'(bus.d0),         m_score % 10);
        check_eq("dp1",        int'(bus.dp1),        m_sat);
        check_eq("dp0",        int'(bus.dp0),        (m_hold > 0) ? 1 : 0);
        check_eq("scan_en",    int'(bus.scan_en),    m_scan);
        check_eq("busy",       int'(bus.busy),       1 - m_idle());
        check_eq("shot_ready", int'(bus.shot_ready), (m_idle() != 0 && c == 0) ? 1 : 0);
    endtask

    // One clock: drive inputs after the falling edge, check, then advance the model on the rising edge.
    task automatic step(input int r, input int c, input int v, input int p);
        rst            = (r != 0);
        bus.clr        = (c != 0);
        bus.shot_valid = (v != 0);
        bus.shot_pts   = 2'(p);
        #1;
        if (r == 0) check_outputs(c);
        @(posedge clk);
        model_edge(r, c, v, p);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && m_idle() == 0; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic shoot(input int p);
        step(0, 0, 1, p);
        wait_idle();
    endtask

    task automatic reach(input int target);
        step(0, 1, 0, 0);
        for (int i = 0; i < 60 && m_score < target; i++)
            shoot((target - m_score) > 3 ? 3 : (target - m_score));
    endtask

    initial begin
        bus.clr        = 1'b0;
        bus.shot_valid = 1'b0;
        bus.shot_pts   = 2'd0;
        @(negedge clk);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 0, 0, 0);

        // 08 + 3 crosses the tens boundary and opens the hold window
        reach(8);
        shoot(3);

        // saturation at 99
        reach(98);
        shoot(3);
        shoot(2);

        // clr during the second ADD cycle of a 2-point shot at 45
        reach(45);
        step(0, 0, 1, 2);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        wait_idle();

        // misses held valid at 37
        reach(37);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0);

        // clr colliding with an offer at 12, then the offer alone
        reach(12);
        step(0, 1, 1, 2);
        step(0, 0, 1, 2);
        wait_idle();

        // reset in the middle of an add
        reach(20);
        step(0, 0, 1, 3);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            int r, c, v, p;
            r = ($urandom_range(0, 999) < 3)  ? 1 : 0;
            c = ($urandom_range(0, 999) < 12) ? 1 : 0;
            v = $urandom_range(0, 1);
            p = $urandom_range(0, 3);
            step(r, c, v, p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/score_bcd_keeper.md
Name: score_bcd_keeper

Overview:
- Upstream feeder for the four-digit seven-segment scan stage: holds the game score as a two-digit BCD value and drives the ones/tens digit nibbles, both decimal-point requests and the ~4 kHz scan_en pulse.
- Accepts scored-shot events from the shot logic through a valid/ready handshake and adds 0–3 points to the score one count per clock.
- After each score change, flags "new score" on dp0 for a programmable number of scan periods.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- SCAN_HZ, 4000, scan pulse rate; DIV = CLK_HZ/SCAN_HZ, integer, DIV ≥ 2 required.
- HOLD_TICKS, 400, scan periods spent in HOLD after a scoring shot; 0 = no HOLD; range 0..65535.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous score clear, active-high.
- shot_valid  in  1  shot event offered.
- shot_pts  in  2  points for the offered shot, 0..3; 0 = miss.
- shot_ready  out  1  high when a shot can be accepted.
- d1  out  4  tens digit, BCD 0..9.
- d0  out  4  ones digit, BCD 0..9.
- dp1  out  1  saturation flag, active-high request.
- dp0  out  1  new-score flag, active-high request.
- scan_en  out  1  one-cycle scan strobe.
- busy  out  1  high in ADD or HOLD.

Behaviour:
- rst: d1=d0=0, dp1=0, dp0=0, scan_en=0, divider count=0, hold_cnt=0, pending=0, state=IDLE, so shot_ready=1 and busy=0.
- Divider:
  - Count runs 0..DIV-1 and wraps to 0.
  - scan_en is registered and high for exactly one cycle each time the count equals DIV-1.
  - First pulse is seen DIV cycles after rst deasserts.
  - Affected only by rst; clr does not touch it.
- shot_ready = (state==IDLE) & ~clr. This is combinational.
- FSM states are IDLE, ADD and HOLD.
- IDLE:
  - On shot_valid & shot_ready with shot_pts≠0: pending←shot_pts, state←ADD.
  - With shot_pts=0: the shot is consumed and nothing else changes.
- ADD:
  - Each edge adds 1 to the BCD score and decrements pending.
  - Score visibly changes on the 1st..pts-th edges after the accept edge.
  - On the edge where pending goes 1→0: if HOLD_TICKS=0, state←IDLE; otherwise state←HOLD and hold_cnt←HOLD_TICKS.
- BCD increment:
  - d0=9 → d0←0 and d1←d1+1.
  - Otherwise d0←d0+1.
  - Digits never leave 0..9.
- Saturation:
  - At 99, increments are suppressed and pending still drains at one per cycle.
  - dp1←1 on the first suppressed increment. dp1 stays 1 until clr or rst.
- HOLD:
  - dp0=1 while in HOLD, 0 elsewhere. dp0 is decoded from the state.
  - On each scan_en, hold_cnt decrements. On scan_en with hold_cnt=1, state←IDLE.
  - shot_valid is ignored.
- clr:
  - Sets d1=d0=0, dp1=0, pending=0, hold_cnt=0 and state←IDLE on that edge.
  - Has priority over any accept or increment in the same cycle; a shot offered with clr high is not accepted.
  - Valid in any state, including mid-ADD and mid-HOLD.
- Reset mid-operation follows the reset values above; no partial add survives.
- Increments occur only in ADD. Digits stay stable for the scan stage at all other times.

Test Plan:
- DIV=4, HOLD_TICKS=2: release rst → scan_en high at cycles 4, 8, 12 only. Until the first accept: d1:d0=00, shot_ready=1, dp0=dp1=0.
- Offer shot_pts=3 at score 08:
  - shot_ready drops the next cycle.
  - Score goes 09, 10, 11 on three consecutive edges.
  - dp0=1 then stays high for exactly 2 scan_en pulses; shot_ready returns after the 2nd pulse.
- Score 98, offer pts=3:
  - Score goes 99 and holds 99.
  - dp1 rises on the next edge and stays 1.
  - busy is high for 3 ADD cycles plus HOLD.
- clr asserted during the 2nd ADD cycle of a pts=2 shot at 45: next cycle d1:d0=00, state IDLE, dp0=0, no further increment.
- shot_valid held high with pts=0 at score 37: score stays 37, shot_ready stays 1, busy never asserts.
- clr and shot_valid (pts=2) together in IDLE at score 12: score 00, shot not accepted; with clr then low, the same offer is accepted next cycle → score 02.
